// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sram_controller
//  Purpose  : Wishbone-side controller for a byte-wide asynchronous SRAM with
//             programmable wait states and MMU violation abort.
//  Revision : 1.0  initial release
// ============================================================================
module sram_controller #(
    parameter int SRAM_ADDR_WIDTH = 21,
    parameter int WAIT_STATES     = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_reset_i,
    input  logic                       wb_strobe_i,
    input  logic                       wb_write_i,
    input  logic [7:0]                 wb_data_i,
    input  logic [24:0]                ram_addr_i,
    input  logic                       access_violation_i,
    output logic [7:0]                 wb_data_o,
    output logic                       wb_ack_o,
    output logic                       wb_stall_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [7:0]                 sram_data_o,
    output logic                       sram_data_oe_o,
    input  logic [7:0]                 sram_data_i,
    output logic                       sram_ce_n_o,
    output logic                       sram_oe_n_o,
    output logic                       sram_we_n_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_RECOVER = 3'd3,
        S_NOMEM   = 3'd4
    } state_t;

    localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

    state_t                     r_state;
    state_t                     w_next;
    logic [SRAM_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                 r_wdata;
    logic [7:0]                 r_rdata;
    logic                       r_we;
    logic                       r_abort;
    logic [3:0]                 r_cnt;
    logic                       w_out_of_range;
    logic                       w_active;

    generate
        if (SRAM_ADDR_WIDTH < 25) begin : g_range_check
            assign w_out_of_range = |ram_addr_i[24:SRAM_ADDR_WIDTH];
        end else begin : g_full_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Controls decode straight from the state register so an async reset
    // releases the SRAM bus in the same cycle it is asserted.
    always_comb begin
        w_next         = r_state;
        w_active       = (r_state == S_SETUP) || (r_state == S_ACCESS);
        wb_ack_o       = 1'b0;
        wb_stall_o     = (r_state != S_IDLE);
        sram_ce_n_o    = ~w_active;
        sram_oe_n_o    = ~(w_active && !r_we);
        sram_we_n_o    = ~((r_state == S_ACCESS) && r_we && !r_abort);
        sram_data_oe_o = r_we && (w_active || (r_state == S_RECOVER));
        case (r_state)
            S_IDLE: begin
                if (wb_strobe_i) begin
                    w_next = w_out_of_range ? S_NOMEM : S_SETUP;
                end
            end
            S_SETUP:   w_next = S_ACCESS;
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RECOVER;
                end
            end
            S_RECOVER: begin
                wb_ack_o = 1'b1;
                w_next   = S_IDLE;
            end
            S_NOMEM: begin
                wb_ack_o = 1'b1;
                w_next   = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Unmapped accesses leave the SRAM-facing registers untouched.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_we    <= 1'b0;
            r_abort <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wb_strobe_i) begin
                        r_we <= wb_write_i;
                        if (w_out_of_range) begin
                            r_rdata <= 8'hFF;
                        end else begin
                            r_addr  <= ram_addr_i[SRAM_ADDR_WIDTH-1:0];
                            r_wdata <= wb_data_i;
                        end
                    end
                end
                S_SETUP: begin
                    r_abort <= access_violation_i;
                    r_cnt   <= C_WAIT;
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            r_rdata <= r_abort ? 8'hFF : sram_data_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_data_o   = r_rdata;
    assign sram_addr_o = r_addr;
    assign sram_data_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_controller
//  Purpose  : Directed self-checking bench for sram_controller (W=2 and W=0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic        we_i = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [24:0] addr_i = 25'd0;
    logic        viol = 1'b0;

    logic [7:0]  dout, dout0;
    logic        ack, ack0, stall, stall0;
    logic [20:0] saddr, saddr0;
    logic [7:0]  sdo, sdo0, sdi;
    logic        doe, doe0, ce_n, ce_n0, oe_n, oe_n0, we_n, we_n0;

    logic [7:0]  mem [0:(1<<21)-1];

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_ack, m_stall, m_ce, m_oe, m_we, m_doe;
    logic [15:0] m_ack0, m_stall0, m_ce0;
    logic [7:0]  ack_data, ack_data0;

    always #5 clk = ~clk;

    sram_controller #(.SRAM_ADDR_WIDTH(21), .WAIT_STATES(2)) dut (
        .wb_clk_i(clk), .wb_reset_i(rst), .wb_strobe_i(strobe), .wb_write_i(we_i),
        .wb_data_i(din), .ram_addr_i(addr_i), .access_violation_i(viol),
        .wb_data_o(dout), .wb_ack_o(ack), .wb_stall_o(stall),
        .sram_addr_o(saddr), .sram_data_o(sdo), .sram_data_oe_o(doe),
        .sram_data_i(sdi), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
    );

    sram_controller #(.SRAM_ADDR_WIDTH(21), .WAIT_STATES(0)) dut0 (
        .wb_clk_i(clk), .wb_reset_i(rst), .wb_strobe_i(strobe), .wb_write_i(we_i),
        .wb_data_i(din), .ram_addr_i(addr_i), .access_violation_i(viol),
        .wb_data_o(dout0), .wb_ack_o(ack0), .wb_stall_o(stall0),
        .sram_addr_o(saddr0), .sram_data_o(sdo0), .sram_data_oe_o(doe0),
        .sram_data_i(8'h3C), .sram_ce_n_o(ce_n0), .sram_oe_n_o(oe_n0), .sram_we_n_o(we_n0)
    );

    // Asynchronous SRAM model attached to the W=2 instance.
    assign sdi = (!ce_n && !oe_n) ? mem[saddr] : 8'h00;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[saddr] <= sdo;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe accepted at edge 0; strobe held through edge 'hold'; violation
    // driven only during cycle 'viol_c'. Per-cycle activity recorded as masks.
    task automatic run(input logic w, input logic [24:0] a, input logic [7:0] d,
                       input int viol_c, input int hold, input int ncyc);
        m_ack = '0; m_stall = '0; m_ce = '0; m_oe = '0; m_we = '0; m_doe = '0;
        m_ack0 = '0; m_stall0 = '0; m_ce0 = '0;
        ack_data = 8'h00; ack_data0 = 8'h00;
        @(negedge clk);
        strobe = 1'b1; we_i = w; addr_i = a; din = d; viol = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            if (c - 1 >= hold) strobe = 1'b0;
            viol = (c == viol_c);
            @(negedge clk);
            m_ack[c]    = ack;     m_stall[c] = stall;  m_ce[c]  = ~ce_n;
            m_oe[c]     = ~oe_n;   m_we[c]    = ~we_n;  m_doe[c] = doe;
            m_ack0[c]   = ack0;    m_stall0[c] = stall0; m_ce0[c] = ~ce_n0;
            if (ack && m_ack == (16'd1 << c)) ack_data = dout;
            if (ack0 && m_ack0 == (16'd1 << c)) ack_data0 = dout0;
            @(posedge clk); #1;
        end
        strobe = 1'b0; viol = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        mem[21'h01234] <= 8'h5A;
        mem[21'h00010] <= 8'h11;
        mem[21'h00030] <= 8'h00;
        mem[21'h1FFFFF] <= 8'h00;
        #3;
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_data",  {24'd0, dout},  32'd0);
        chk("rst_ctl",   {28'd0, ce_n, oe_n, we_n, doe}, 32'hE);
        chk("rst_addr",  {11'd0, saddr}, 32'd0);
        chk("rst_wdata", {24'd0, sdo},   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run(1'b0, 25'h0001234, 8'h00, 0, 0, 7);
        chk("rd_ack",   {16'd0, m_ack},   32'h20);
        chk("rd_stall", {16'd0, m_stall}, 32'h3E);
        chk("rd_oe",    {16'd0, m_oe},    32'h1E);
        chk("rd_doe",   {16'd0, m_doe},   32'h00);
        chk("rd_data",  {24'd0, ack_data}, 32'h5A);

        run(1'b1, 25'h01FFFFF, 8'hC3, 0, 0, 7);
        chk("wr_we",  {16'd0, m_we},  32'h1C);
        chk("wr_doe", {16'd0, m_doe}, 32'h3E);
        chk("wr_oe",  {16'd0, m_oe},  32'h00);
        chk("wr_ack", {16'd0, m_ack}, 32'h20);
        chk("wr_mem", {24'd0, mem[21'h1FFFFF]}, 32'hC3);

        run(1'b1, 25'h0000010, 8'h77, 1, 0, 7);
        chk("ab_we",  {16'd0, m_we},  32'h00);
        chk("ab_ce",  {16'd0, m_ce},  32'h1E);
        chk("ab_ack", {16'd0, m_ack}, 32'h20);
        chk("ab_mem", {24'd0, mem[21'h00010]}, 32'h11);

        run(1'b1, 25'h0000030, 8'h44, 2, 0, 7);
        chk("lv_we",  {16'd0, m_we}, 32'h1C);
        chk("lv_mem", {24'd0, mem[21'h00030]}, 32'h44);

        run(1'b0, 25'h0200000, 8'h00, 0, 2, 5);
        chk("oor_ce",    {16'd0, m_ce},    32'h00);
        chk("oor_ack",   {16'd0, m_ack},   32'h0A);
        chk("oor_stall", {16'd0, m_stall}, 32'h0A);
        chk("oor_data",  {24'd0, ack_data}, 32'hFF);

        run(1'b0, 25'h0000100, 8'h00, 0, 4, 9);
        chk("b2b_ack",   {16'd0, m_ack0},   32'h88);
        chk("b2b_ce",    {16'd0, m_ce0},    32'h66);
        chk("b2b_stall", {16'd0, m_stall0}, 32'hEE);
        chk("b2b_data",  {24'd0, ack_data0}, 32'h3C);

        @(negedge clk);
        strobe = 1'b1; we_i = 1'b1; addr_i = 25'h0000020; din = 8'h99;
        @(posedge clk); #1;
        strobe = 1'b0;
        @(posedge clk); #1;
        chk("mr_pre_we", {31'd0, we_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mr_we",  {31'd0, we_n}, 32'd1);
        chk("mr_ce",  {31'd0, ce_n}, 32'd1);
        chk("mr_doe", {31'd0, doe},  32'd0);
        chk("mr_ack", {31'd0, ack},  32'd0);
        @(negedge clk);
        chk("mr_ack_hold", {31'd0, ack}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run(1'b0, 25'h0001234, 8'h00, 0, 0, 7);
        chk("mr_rd_ack",  {16'd0, m_ack}, 32'h20);
        chk("mr_rd_data", {24'd0, ack_data}, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
